// File: rtl/sram_bank_sequencer.sv
// Transaction sequencer for the 16x32 two-port adiabatic SRAM bank, timed to the 10-phase Bennett clock.
// Optional read/write completion counters are enabled by defining SRAM_SEQ_PERF_EN.
module sram_bank_sequencer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  clkpos,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [4:0]        req_addr_a,
  input  logic [4:0]        req_addr_b,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata_a,
  output logic [15:0]       rsp_rdata_b,
  output logic [4:0]        Addr_A,
  output logic [4:0]        Addr_B,
  output logic [15:0]       in,
  output logic              ReadEn,
  output logic              WriteEn,
  output logic              RegWrtBar,
  input  logic [15:0]       outA,
  input  logic [15:0]       outB
`ifdef SRAM_SEQ_PERF_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ADDR,
    WAIT_DATA,
    WAIT_CTRL,
    WAIT_EN,
    WAIT_END,
    WAIT_CAP
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] ph_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             unused_edges;

  logic             ready_q;
  logic             wr_q;
  logic [4:0]       lat_addr_a_q;
  logic [4:0]       lat_addr_b_q;
  logic [15:0]      lat_wdata_q;
  logic             r9_q;

  logic [4:0]       addr_a_q;
  logic [4:0]       addr_b_q;
  logic [15:0]      din_q;
  logic             ren_q;
  logic             wen_q;
  logic             rwb_q;
  logic             rsp_valid_q;
  logic [15:0]      rdata_a_q;
  logic [15:0]      rdata_b_q;

  assign rise = clkpos & ~ph_q;
  assign fall = ~clkpos & ph_q;
  // Only a handful of phase edges sequence the bank; the rest are intentionally ignored.
  assign unused_edges = ^{rise, fall};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ph_q         <= '0;
      ready_q      <= 1'b1;
      wr_q         <= 1'b0;
      lat_addr_a_q <= '0;
      lat_addr_b_q <= '0;
      lat_wdata_q  <= '0;
      r9_q         <= 1'b0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      din_q        <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      rwb_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      ph_q        <= clkpos;
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Phase edges seen in the accept cycle are ignored, so a request
          // arriving with rise[2] waits for the next Bennett cycle.
          if (req_valid && ready_q) begin
            ready_q      <= 1'b0;
            wr_q         <= req_write;
            lat_addr_a_q <= req_addr_a;
            lat_addr_b_q <= req_addr_b;
            lat_wdata_q  <= req_wdata;
            r9_q         <= 1'b0;
            state_q      <= WAIT_ADDR;
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT_ADDR: begin
          if (rise[2]) begin
            addr_a_q <= lat_addr_a_q;
            addr_b_q <= lat_addr_b_q;
            state_q  <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (rise[4]) begin
            din_q   <= wr_q ? lat_wdata_q : 16'h0000;
            state_q <= WAIT_CTRL;
          end
        end
        WAIT_CTRL: begin
          if (rise[6]) begin
            if (wr_q) rwb_q <= 1'b1;
            else      ren_q <= 1'b1;
            state_q <= WAIT_EN;
          end
        end
        WAIT_EN: begin
          if (rise[8]) begin
            if (wr_q) wen_q <= 1'b1;
            else      ren_q <= 1'b0;
            state_q <= WAIT_END;
          end
        end
        WAIT_END: begin
          // Writes need both rise[9] and the later fall[9]; r9_q remembers the first.
          if (wr_q) begin
            if (rise[9]) begin
              wen_q <= 1'b0;
              r9_q  <= 1'b1;
            end else if (r9_q && fall[9]) begin
              rwb_q   <= 1'b0;
              r9_q    <= 1'b0;
              state_q <= IDLE;
            end
          end else if (rise[9]) begin
            state_q <= WAIT_CAP;
          end
        end
        WAIT_CAP: begin
          if (fall[0]) begin
            rdata_a_q   <= outA;
            rdata_b_q   <= outB;
            rsp_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata_a = rdata_a_q;
  assign rsp_rdata_b = rdata_b_q;
  assign Addr_A      = addr_a_q;
  assign Addr_B      = addr_b_q;
  assign in          = din_q;
  assign ReadEn      = ren_q;
  assign WriteEn     = wen_q;
  assign RegWrtBar   = rwb_q;

`ifdef SRAM_SEQ_PERF_EN
  logic        wr_done;
  logic        rd_done;
  logic [15:0] rd_cnt_q;
  logic [15:0] rd_cnt_d;
  logic [15:0] wr_cnt_q;
  logic [15:0] wr_cnt_d;

  assign wr_done = (state_q == WAIT_END) && wr_q && r9_q && fall[9];
  assign rd_done = (state_q == WAIT_CAP) && fall[0];

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_done && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_done && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Randomized bench for sram_bank_sequencer: a Bennett step generator, a behavioural bank,
// and a step-schedule reference model checked against every output each clk.
module tb_sram_bank_sequencer;

  localparam int unsigned S = 3;  // clk cycles per Bennett step; 20 steps per Bennett cycle

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  clkpos;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr_a;
  logic [4:0]  req_addr_b;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata_a;
  logic [15:0] rsp_rdata_b;
  logic [4:0]  Addr_A;
  logic [4:0]  Addr_B;
  logic [15:0] din;
  logic        ReadEn;
  logic        WriteEn;
  logic        RegWrtBar;
  logic [15:0] outA;
  logic [15:0] outB;
`ifdef SRAM_SEQ_PERF_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  always #5 clk = ~clk;

  sram_bank_sequencer #(.WIDTH(10)) dut (
    .clk(clk), .reset(reset), .clkpos(clkpos),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata_a(rsp_rdata_a), .rsp_rdata_b(rsp_rdata_b),
    .Addr_A(Addr_A), .Addr_B(Addr_B), .in(din),
    .ReadEn(ReadEn), .WriteEn(WriteEn), .RegWrtBar(RegWrtBar),
    .outA(outA), .outB(outB)
`ifdef SRAM_SEQ_PERF_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  // Behavioural bank: writes on WriteEn, read ports follow the addresses.
  logic [15:0] bank [32];
  logic [15:0] ref_mem [32];
  assign outA = bank[Addr_A];
  assign outB = bank[Addr_B];
  always @(posedge clk) if (WriteEn) bank[Addr_A] <= din;

  // Bennett generator: steps 0..9 raise phases 0..9, steps 10..19 drop phases 9..0.
  int unsigned g = 0;
  bit          hold_req = 1'b0;

  function automatic logic [9:0] pat(input int unsigned s);
    logic [9:0] ones;
    ones = '1;
    if (s < 10)      return ones >> (9 - s);
    else if (s < 19) return ones >> (s - 9);
    else             return '0;
  endfunction

  initial clkpos = pat(0);
  always @(negedge clk) begin
    if (!(hold_req && (((g / S) % 20) == 19))) g++;
    clkpos = pat((g / S) % 20);
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction runs on the Bennett cycle whose step 2 starts after acceptance.
  int unsigned g_seen = 32'hFFFF_FFFF;
  int unsigned m_s, m_bc, m_tc;
  bit          m_new;
  bit          m_busy = 1'b0;
  bit          m_ready = 1'b1;
  bit          m_wr;
  logic [4:0]  m_ta, m_tb;
  logic [15:0] m_td;
  int unsigned acc_cnt = 0;
  logic [4:0]  e_addr_a = '0, e_addr_b = '0;
  logic [15:0] e_in = '0, e_rda = '0, e_rdb = '0;
  logic        e_ren = 1'b0, e_wen = 1'b0, e_rwb = 1'b0, e_rsp = 1'b0;
  logic [15:0] m_rd_cnt = '0, m_wr_cnt = '0;

  always @(posedge clk) begin
    m_s    = (g / S) % 20;
    m_bc   = g / (S * 20);
    m_new  = (g != g_seen) && ((g % S) == 0);
    g_seen = g;
    if (!reset) begin
      m_busy = 1'b0; m_ready = 1'b1;
      e_addr_a = '0; e_addr_b = '0; e_in = '0; e_rda = '0; e_rdb = '0;
      e_ren = 1'b0; e_wen = 1'b0; e_rwb = 1'b0; e_rsp = 1'b0;
      m_rd_cnt = '0; m_wr_cnt = '0;
    end else begin
      e_rsp = 1'b0;
      if (m_busy) begin
        if (m_new && (m_bc == m_tc)) begin
          if (m_s == 2) begin e_addr_a = m_ta; e_addr_b = m_tb; end
          if (m_s == 4) e_in = m_wr ? m_td : 16'h0000;
          if (m_s == 6) begin if (m_wr) e_rwb = 1'b1; else e_ren = 1'b1; end
          if (m_s == 8) begin if (m_wr) e_wen = 1'b1; else e_ren = 1'b0; end
          if (m_s == 9) e_wen = 1'b0;
          if ((m_s == 10) && m_wr) begin
            e_rwb = 1'b0; m_busy = 1'b0; ref_mem[m_ta] = m_td;
            if (m_wr_cnt != 16'hFFFF) m_wr_cnt++;
          end
          if ((m_s == 19) && !m_wr) begin
            e_rda = ref_mem[m_ta]; e_rdb = ref_mem[m_tb]; e_rsp = 1'b1; m_busy = 1'b0;
            if (m_rd_cnt != 16'hFFFF) m_rd_cnt++;
          end
        end
      end else if (m_ready && req_valid) begin
        m_ready = 1'b0; m_busy = 1'b1; acc_cnt++;
        m_wr = req_write; m_ta = req_addr_a; m_tb = req_addr_b; m_td = req_wdata;
        m_tc = (m_s < 2) ? m_bc : m_bc + 1;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check_eq("req_ready", req_ready, m_ready);
    check_eq("Addr_A", Addr_A, e_addr_a);
    check_eq("Addr_B", Addr_B, e_addr_b);
    check_eq("in", din, e_in);
    check_eq("ReadEn", ReadEn, e_ren);
    check_eq("WriteEn", WriteEn, e_wen);
    check_eq("RegWrtBar", RegWrtBar, e_rwb);
    check_eq("rsp_valid", rsp_valid, e_rsp);
    check_eq("rsp_rdata_a", rsp_rdata_a, e_rda);
    check_eq("rsp_rdata_b", rsp_rdata_b, e_rdb);
`ifdef SRAM_SEQ_PERF_EN
    check_eq("rd_count", rd_count, m_rd_cnt);
    check_eq("wr_count", wr_count, m_wr_cnt);
`endif
  end

  task automatic issue(input bit wr, input logic [4:0] a, input logic [4:0] b, input logic [15:0] d);
    int unsigned base;
    base = acc_cnt;
    req_valid = 1'b1; req_write = wr; req_addr_a = a; req_addr_b = b; req_wdata = d;
    for (int i = 0; i < 600 && acc_cnt == base; i++) @(negedge clk);
    if (acc_cnt == base) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && (m_busy || !m_ready); i++) @(negedge clk);
    if (m_busy || !m_ready) check_eq("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_step(input int unsigned s);
    for (int i = 0; i < 600 && !(m_new && m_s == s); i++) @(negedge clk);
    if (!(m_new && m_s == s)) check_eq("step_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] old_a;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr_a = '0; req_addr_b = '0; req_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      bank[i] = 16'($urandom);
      ref_mem[i] = bank[i];
    end
    repeat (4) @(negedge clk);
    check_eq("rst_ready", req_ready, 64'd1);
    check_eq("rst_addr", {Addr_A, Addr_B}, 64'd0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);

    // Directed write then read of the same locations.
    issue(1'b1, 5'd1, 5'd4, 16'hAAAA);
    req_valid = 1'b0;
    wait_idle();
    issue(1'b0, 5'd1, 5'd4, 16'h0000);
    req_valid = 1'b0;
    wait_idle();
    check_eq("rd_after_wr", rsp_rdata_a, 64'hAAAA);

    // Back-to-back with req_valid held across both requests.
    issue(1'b1, 5'd9, 5'd2, 16'h1234);
    issue(1'b0, 5'd9, 5'd1, 16'h0000);
    req_valid = 1'b0;
    wait_idle();

    // Late accept: request lands one clk after rise[2]; the address must hold until the next cycle.
    wait_step(2);
    old_a = e_addr_a;
    issue(1'b1, 5'd7, 5'd3, 16'h5A5A);
    req_valid = 1'b0;
    wait_step(10);
    check_eq("late_addr_hold", Addr_A, old_a);
    wait_idle();
    check_eq("late_addr_new", Addr_A, 64'd7);

    // Reset between rise[6] and rise[8] of a read.
    issue(1'b0, 5'd7, 5'd9, 16'h0000);
    req_valid = 1'b0;
    for (int i = 0; i < 600 && !e_ren; i++) @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("midrst_ren", ReadEn, 64'd0);
    check_eq("midrst_rsp", rsp_valid, 64'd0);
    check_eq("midrst_addr", Addr_A, 64'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("postrst_ready", req_ready, 64'd1);
    repeat (70) @(negedge clk);

    // Randomized traffic with generator holds and back-to-back requests.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        hold_req = 1'b1;
        repeat ($urandom_range(5, 30)) @(negedge clk);
        hold_req = 1'b0;
      end
      repeat ($urandom_range(0, 25)) @(negedge clk);
      issue(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0)
        issue(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
      req_valid = 1'b0;
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
